// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter update unit: address width,
// default vectors, named next-PC source indices and a clog2 helper.
package pc_pkg;

  // Default datapath address width
  localparam int unsigned PC_W = 32;

  // Default PC after reset and default trap target
  localparam logic [PC_W-1:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_EXC_VECTOR   = 32'h0000_00FF;

  // Default number of candidate sources
  localparam int unsigned PC_NUM_SRC = 5;

  // Named candidate source indices for the default configuration
  typedef enum logic [2:0] {
    SRC_PC4    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_ALUOUT = 3'd3,
    SRC_EPC    = 3'd4
  } pc_src_e;

  // Ceiling log2, with a minimum result of 1 so a select port is never zero width
  function automatic int pc_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : pc_pkg

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC:1 next-PC candidate selector. Any select value that
// does not address a real source raises bad_sel and yields EXC_VECTOR.
module pc_src_mux
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH      = PC_W,
  parameter int unsigned     NUM_SRC    = PC_NUM_SRC,
  parameter int unsigned     SEL_W      = pc_clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = PC_EXC_VECTOR
) (
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         cand,
  output logic                     bad_sel
);

  // Unpacked view of the packed candidate bus
  logic [WIDTH-1:0] src_arr [NUM_SRC];

  // Split packed input into per-source words
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_arr[i] = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Decode select; unmatched select values fall through to the trap vector
  always_comb begin
    cand    = EXC_VECTOR;
    bad_sel = 1'b1;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        cand    = src_arr[i];
        bad_sel = 1'b0;
      end
    end
  end

endmodule : pc_src_mux

// File: rtl/pc_update_unit.sv
// Next-PC selection plus program-counter register for the multicycle CPU.
// Loads the selected candidate under unconditional or branch-conditional
// control, traps illegal selects and misaligned targets to EXC_VECTOR,
// remembers the previous PC for EPC and keeps sticky error flags.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_W,
  parameter int unsigned      NUM_SRC      = PC_NUM_SRC,
  parameter int unsigned      SEL_W        = pc_clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = PC_EXC_VECTOR,
  parameter bit               ALIGN_CHECK  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]         pc_src,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_flag,
  input  logic                     stall,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     pc_updated,
  output logic                     sel_err,
  output logic                     misalign_err
);

  logic [WIDTH-1:0] cand;
  logic             bad_sel;
  logic             bad_align;
  logic             load;
  logic [WIDTH-1:0] next_pc;

  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] pc_prev_q,  pc_prev_d;
  logic             updated_q,  updated_d;
  logic             sel_err_q,  sel_err_d;
  logic             align_err_q, align_err_d;

  pc_src_mux #(
    .WIDTH      (WIDTH),
    .NUM_SRC    (NUM_SRC),
    .SEL_W      (SEL_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_src_mux (
    .data_in (data_in),
    .sel     (pc_src),
    .cand    (cand),
    .bad_sel (bad_sel)
  );

  // Load qualification and trap redirection; the trap vector is never align-checked
  always_comb begin
    load      = ~stall & (pc_write | (pc_write_cond & cond_flag));
    bad_align = ALIGN_CHECK & ~bad_sel & (cand[1:0] != 2'b00);
    next_pc   = (bad_sel | bad_align) ? EXC_VECTOR : cand;
  end

  // Next-state for PC, previous PC, update pulse and sticky flags
  always_comb begin
    pc_d        = pc_q;
    pc_prev_d   = pc_prev_q;
    updated_d   = 1'b0;
    sel_err_d   = err_clr ? 1'b0 : sel_err_q;
    align_err_d = err_clr ? 1'b0 : align_err_q;
    if (load) begin
      pc_d      = next_pc;
      pc_prev_d = pc_q;
      updated_d = 1'b1;
      // A fresh error on the clearing edge wins over err_clr
      if (bad_sel) begin
        sel_err_d = 1'b1;
      end
      if (bad_align) begin
        align_err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VECTOR;
      pc_prev_q   <= RESET_VECTOR;
      updated_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_prev_q   <= pc_prev_d;
      updated_q   <= updated_d;
      sel_err_q   <= sel_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_prev      = pc_prev_q;
  assign pc_updated   = updated_q;
  assign sel_err      = sel_err_q;
  assign misalign_err = align_err_q;

endmodule : pc_update_unit

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit at default parameters.
module tb_pc_update_unit;
  import pc_pkg::*;

  logic         clk;
  logic         reset_n;
  logic [159:0] data_in;
  logic [2:0]   pc_src;
  logic         pc_write;
  logic         pc_write_cond;
  logic         cond_flag;
  logic         stall;
  logic         err_clr;
  logic [31:0]  pc_out;
  logic [31:0]  pc_prev;
  logic         pc_updated;
  logic         sel_err;
  logic         misalign_err;

  int unsigned total;
  int unsigned bad;

  pc_update_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_flag     (cond_flag),
    .stall         (stall),
    .err_clr       (err_clr),
    .pc_out        (pc_out),
    .pc_prev       (pc_prev),
    .pc_updated    (pc_updated),
    .sel_err       (sel_err),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int unsigned idx, input logic [31:0] val);
    data_in[idx*32 +: 32] = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    data_in = '0;
    pc_src = '0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    cond_flag = 1'b0;
    stall = 1'b0;
    err_clr = 1'b0;

    // 1. Reset state
    #12;
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_prev",  pc_prev, 32'h0);
    chk("rst_upd",   {31'b0, pc_updated}, 32'h0);
    chk("rst_sel",   {31'b0, sel_err}, 32'h0);
    chk("rst_align", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_pc",  pc_out, 32'h0);
    chk("idle_upd", {31'b0, pc_updated}, 32'h0);

    // 2. Sweep all sources back to back
    for (int unsigned i = 0; i < 5; i++) set_src(i, 32'h100 + 32'(4*i));
    pc_write = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      pc_src = 3'(i);
      tick();
      chk("sweep_pc",   pc_out, 32'h100 + 32'(4*i));
      chk("sweep_prev", pc_prev, (i == 0) ? 32'h0 : 32'h100 + 32'(4*(i-1)));
      chk("sweep_upd",  {31'b0, pc_updated}, 32'h1);
    end

    // 3. Conditional branch
    pc_write = 1'b0;
    pc_write_cond = 1'b1;
    set_src(SRC_BRANCH, 32'h200);
    pc_src = SRC_BRANCH;
    cond_flag = 1'b0;
    tick();
    chk("br_nt_pc",  pc_out, 32'h110);
    chk("br_nt_upd", {31'b0, pc_updated}, 32'h0);
    cond_flag = 1'b1;
    tick();
    chk("br_t_pc",   pc_out, 32'h200);
    chk("br_t_prev", pc_prev, 32'h110);
    chk("br_t_upd",  {31'b0, pc_updated}, 32'h1);

    // 4. Stall suppresses the load
    pc_write_cond = 1'b0;
    cond_flag = 1'b0;
    pc_write = 1'b1;
    stall = 1'b1;
    pc_src = SRC_JUMP;
    tick();
    chk("stall_pc",  pc_out, 32'h200);
    chk("stall_upd", {31'b0, pc_updated}, 32'h0);
    stall = 1'b0;
    tick();
    chk("unstall_pc",   pc_out, 32'h108);
    chk("unstall_prev", pc_prev, 32'h200);

    // 5. Traps and sticky flags
    pc_src = 3'd7;
    tick();
    chk("bsel_pc",    pc_out, 32'hFF);
    chk("bsel_prev",  pc_prev, 32'h108);
    chk("bsel_sel",   {31'b0, sel_err}, 32'h1);
    chk("bsel_align", {31'b0, misalign_err}, 32'h0);
    set_src(SRC_PC4, 32'h102);
    pc_src = SRC_PC4;
    tick();
    chk("mis_pc",    pc_out, 32'hFF);
    chk("mis_prev",  pc_prev, 32'hFF);
    chk("mis_align", {31'b0, misalign_err}, 32'h1);
    pc_src = 3'd7;
    err_clr = 1'b1;
    tick();
    chk("clr_race_sel",   {31'b0, sel_err}, 32'h1);
    chk("clr_race_align", {31'b0, misalign_err}, 32'h0);
    pc_write = 1'b0;
    tick();
    chk("clr_sel",   {31'b0, sel_err}, 32'h0);
    chk("clr_align", {31'b0, misalign_err}, 32'h0);
    err_clr = 1'b0;
    tick();
    chk("ign_sel", {31'b0, sel_err}, 32'h0);
    chk("ign_pc",  pc_out, 32'hFF);

    // 6. Asynchronous reset between edges
    pc_write = 1'b1;
    pc_src = SRC_EPC;
    tick();
    chk("pre_rst_pc", pc_out, 32'h110);
    pc_write = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pc",   pc_out, 32'h0);
    chk("arst_prev", pc_prev, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pc_write = 1'b1;
    tick();
    chk("post_rst_pc",   pc_out, 32'h110);
    chk("post_rst_prev", pc_prev, 32'h0);
    chk("post_rst_upd",  {31'b0, pc_updated}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_update_unit
